main_mem_ctrl: RTL and testbench

//  Responder end of the cache<->main-memory block interface. Accepts one block

---
 rtl/main_mem_ctrl_pkg.sv | 21 ++
 rtl/main_mem_ctrl_mem_block_array.sv | 59 +++++
 rtl/main_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_main_mem_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// main_mem_ctrl_pkg
// Shared definitions for the main-memory responder: FSM state encoding and
// the geometry of the 1 KiB backing array (256 words of 32 bits, 4 words per
// 128-bit block).
// ---------------------------------------------------------------------------
package main_mem_ctrl_pkg;

    localparam int BLOCK_W   = 128;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 256;

    // IDLE accepts a request, BUSY models the access latency, RESP is the
    // single cycle in which the response strobe is high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/main_mem_ctrl_mem_block_array.sv
// ---------------------------------------------------------------------------
// mem_block_array
// 256 x 32 storage addressed by block. A block is BLOCK_WORDS consecutive
// words starting at word blockIdx*BLOCK_WORDS.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high; reloads word i with the value i
//   wrEn      perform a masked block write on this edge
//   blockIdx  block being read and/or written
//   wdata     write block, word w at bits [32w+31:32w]
//   wmask     per-word write enable
//   rdata     combinational read of the addressed block
// ---------------------------------------------------------------------------
module mem_block_array
    import main_mem_ctrl_pkg::*;
#(
    parameter int IDX_W       = 6,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wrEn,
    input  logic [IDX_W-1:0]              blockIdx,
    input  logic [BLOCK_WORDS*WORD_W-1:0] wdata,
    input  logic [BLOCK_WORDS-1:0]        wmask,
    output logic [BLOCK_WORDS*WORD_W-1:0] rdata
);

    localparam int OFF_W  = $clog2(BLOCK_WORDS);
    localparam int WADR_W = IDX_W + OFF_W;

    logic [WORD_W-1:0] mem [NUM_WORDS];

    // Reset loads a recognisable pattern (word i holds i) so that reads of
    // untouched blocks are predictable. Reset has priority, so a write that
    // coincides with reset is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= {24'h0, i[7:0]};
            end
        end else if (wrEn) begin
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                if (wmask[w]) begin
                    mem[WADR_W'({blockIdx, w[OFF_W-1:0]})] <= wdata[w*WORD_W +: WORD_W];
                end
            end
        end
    end

    // Whole-block combinational read; word w of the block lands in lane w.
    always_comb begin
        rdata = '0;
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            rdata[w*WORD_W +: WORD_W] = mem[WADR_W'({blockIdx, w[OFF_W-1:0]})];
        end
    end

endmodule

// File: rtl/main_mem_ctrl.sv
// ---------------------------------------------------------------------------
// main_mem_ctrl
// Responder side of the cache <-> main-memory block interface. Accepts one
// block request, waits LATENCY cycles, performs the read or masked write and
// returns the resulting block with a one-cycle resp_valid strobe.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   req_valid    request present
//   req_ready    high only while idle
//   req_write    0 = read, 1 = masked write
//   req_addr     byte address, block index = req_addr[9:4]
//   req_wdata    write block, word w at bits [32w+31:32w]
//   req_wmask    per-word write enable
//   resp_valid   one-cycle completion strobe
//   resp_rdata   block contents after the access, held between responses
//   busy         high whenever not idle
// ---------------------------------------------------------------------------
module main_mem_ctrl
    import main_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [BLOCK_WORDS*WORD_W-1:0] req_wdata,
    input  logic [BLOCK_WORDS-1:0]        req_wmask,
    output logic                          resp_valid,
    output logic [BLOCK_WORDS*WORD_W-1:0] resp_rdata,
    output logic                          busy
);

    localparam int IDX_W  = ADDR_W - 4;
    localparam int CNT_W  = 4;
    localparam int DATA_W = BLOCK_WORDS * WORD_W;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                capWrite;
    logic [IDX_W-1:0]    capIdx;
    logic [DATA_W-1:0]   capWdata;
    logic [BLOCK_WORDS-1:0] capWmask;
    logic                reqReadyReg;
    logic                busyReg;
    logic                respValidReg;
    logic [DATA_W-1:0]   respRdataReg;

    logic                accessNow;
    logic                memWrEn;
    logic [DATA_W-1:0]   memRdata;
    logic [DATA_W-1:0]   mergedBlock;
    logic                unusedOffsetBits;

    // The byte/word offset within a block never affects the access.
    assign unusedOffsetBits = ^req_addr[3:0];

    // The access happens on the last BUSY edge; the array write and the
    // response register load occur on that same edge.
    assign accessNow = (state == BUSY) && (cnt == '0);
    assign memWrEn   = accessNow && capWrite;

    mem_block_array #(
        .IDX_W       (IDX_W),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) memArray (
        .clk      (clk),
        .reset    (reset),
        .wrEn     (memWrEn),
        .blockIdx (capIdx),
        .wdata    (capWdata),
        .wmask    (capWmask),
        .rdata    (memRdata)
    );

    // The response reflects the post-write block: written lanes come from the
    // request, the rest from the array. For a read the mask is ignored.
    always_comb begin
        mergedBlock = memRdata;
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            if (capWrite && capWmask[w]) begin
                mergedBlock[w*WORD_W +: WORD_W] = capWdata[w*WORD_W +: WORD_W];
            end
        end
    end

    // Request FSM. All outputs are registered and updated together with the
    // state, so req_ready/busy always agree with the state they describe.
    // Reset aborts any access in flight; the array drops the write itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            capWrite     <= 1'b0;
            capIdx       <= '0;
            capWdata     <= '0;
            capWmask     <= '0;
            reqReadyReg  <= 1'b1;
            busyReg      <= 1'b0;
            respValidReg <= 1'b0;
            respRdataReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    respValidReg <= 1'b0;
                    if (req_valid && reqReadyReg) begin
                        capWrite    <= req_write;
                        capIdx      <= req_addr[ADDR_W-1:4];
                        capWdata    <= req_wdata;
                        capWmask    <= req_wmask;
                        cnt         <= CNT_W'(LATENCY - 1);
                        state       <= BUSY;
                        reqReadyReg <= 1'b0;
                        busyReg     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        respRdataReg <= mergedBlock;
                        respValidReg <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    respValidReg <= 1'b0;
                    reqReadyReg  <= 1'b1;
                    busyReg      <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    respValidReg <= 1'b0;
                    reqReadyReg  <= 1'b1;
                    busyReg      <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = reqReadyReg;
    assign busy       = busyReg;
    assign resp_valid = respValidReg;
    assign resp_rdata = respRdataReg;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_main_mem_ctrl
// Self-checking bench for main_mem_ctrl. A LATENCY=4 instance carries most of
// the traffic; a LATENCY=1 instance checks the minimum-latency build. Expected
// blocks come from a flat word-array model of the 1 KiB memory.
// ---------------------------------------------------------------------------
module tb_main_mem_ctrl;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         reset;

    logic         req_valid, req_ready, req_write, resp_valid, busy;
    logic [9:0]   req_addr;
    logic [127:0] req_wdata, resp_rdata;
    logic [3:0]   req_wmask;

    logic         req_valid1, req_ready1, resp_valid1, busy1;
    logic [9:0]   req_addr1;
    logic [127:0] resp_rdata1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [256];

    typedef struct {
        string        name;
        bit           write;
        logic [9:0]   addr;
        logic [127:0] wdata;
        logic [3:0]   wmask;
        logic [127:0] expData;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    main_mem_ctrl #(.ADDR_W(10), .BLOCK_WORDS(4), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy)
    );

    main_mem_ctrl #(.ADDR_W(10), .BLOCK_WORDS(4), .LATENCY(1)) dutLat1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid1),
        .req_ready  (req_ready1),
        .req_write  (1'b0),
        .req_addr   (req_addr1),
        .req_wdata  (128'h0),
        .req_wmask  (4'h0),
        .resp_valid (resp_valid1),
        .resp_rdata (resp_rdata1),
        .busy       (busy1)
    );

    // Memory model: a flat array of words, block b = words 4b..4b+3.
    function automatic void modelReset();
        for (int i = 0; i < 256; i++) model[i] = i;
    endfunction

    function automatic void modelWrite(logic [9:0] addr, logic [127:0] wdata, logic [3:0] wmask);
        int base = int'(addr) / 16 * 4;
        for (int w = 0; w < 4; w++)
            if (wmask[w]) model[base + w] = wdata[w*32 +: 32];
    endfunction

    function automatic logic [127:0] modelBlock(logic [9:0] addr);
        logic [127:0] b;
        int base = int'(addr) / 16 * 4;
        for (int w = 0; w < 4; w++) b[w*32 +: 32] = model[base + w];
        return b;
    endfunction

    task automatic checkOutput(string name, logic [127:0] actual, logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // One full transaction on the LATENCY=4 instance: wait for ready, hold the
    // request for exactly the accept edge, then time and check the response.
    task automatic applyStimulus(string name, bit wr, logic [9:0] addr,
                                 logic [127:0] wdata, logic [3:0] wmask,
                                 logic [127:0] expData);
        int n;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            checkOutput({name, " accept timeout"}, 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        req_wmask = ~wmask;
        checkOutput({name, " busy after accept"}, {busy, req_ready}, 2'b10);
        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        checkOutput({name, " latency"}, n, LAT);
        checkOutput({name, " rdata"}, resp_rdata, expData);
        @(posedge clk); #1;
        checkOutput({name, " strobe one cycle"}, {resp_valid, req_ready, busy}, 3'b010);
        checkOutput({name, " rdata hold"}, resp_rdata, expData);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [9:0]   addrs [3];
        logic [127:0] exps  [3];
        int           accepted, seen, lastT, cyc, readyBusy, extra;
        bit           willAccept;
        logic [127:0] exp;
        bit           wr;
        logic [9:0]   a;
        logic [127:0] d;
        logic [3:0]   m;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wmask  = '0;
        req_valid1 = 1'b0;
        req_addr1  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        modelReset();

        checkOutput("reset ready/busy/valid", {req_ready, busy, resp_valid}, 3'b100);
        checkOutput("reset rdata", resp_rdata, 128'h0);

        // Directed table: basic read, partial write, re-read with offset bits,
        // empty-mask write and its re-read.
        vecs[0] = '{"read 010", 1'b0, 10'h010, 128'h0, 4'h0,
                    {32'h7, 32'h6, 32'h5, 32'h4}};
        vecs[1] = '{"write 020 mask 0100", 1'b1, 10'h020,
                    {32'h11111111, 32'hDEADBEEF, 32'h22222222, 32'h33333333}, 4'b0100,
                    {32'hB, 32'hDEADBEEF, 32'h9, 32'h8}};
        vecs[2] = '{"reread 02C", 1'b0, 10'h02C, 128'h0, 4'h0,
                    {32'hB, 32'hDEADBEEF, 32'h9, 32'h8}};
        vecs[3] = '{"write 040 mask 0", 1'b1, 10'h040, {4{32'hFFFFFFFF}}, 4'h0,
                    {32'h13, 32'h12, 32'h11, 32'h10}};
        vecs[4] = '{"reread 04F", 1'b0, 10'h04F, 128'h0, 4'h0,
                    {32'h13, 32'h12, 32'h11, 32'h10}};
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].write) modelWrite(vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
            applyStimulus(vecs[i].name, vecs[i].write, vecs[i].addr, vecs[i].wdata,
                          vecs[i].wmask, vecs[i].expData);
        end

        // Random mix of reads and masked writes against the model.
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 10'($urandom);
            d  = {$urandom, $urandom, $urandom, $urandom};
            m  = 4'($urandom);
            if (wr) modelWrite(a, d, m);
            exp = modelBlock(a);
            applyStimulus($sformatf("random %0d", i), wr, a, d, m, exp);
        end

        // req_valid held high across three reads: ready must stay low while
        // busy, responses six cycles apart, each read answered exactly once.
        for (int i = 0; i < 3; i++) begin
            addrs[i] = 10'($urandom);
            exps[i]  = modelBlock(addrs[i]);
        end
        req_write = 1'b0;
        req_addr  = addrs[0];
        req_valid = 1'b1;
        accepted = 0; seen = 0; lastT = 0; cyc = 0; readyBusy = 0;
        while (seen < 3 && cyc < 100) begin
            willAccept = req_valid && req_ready;
            @(posedge clk); #1; cyc++;
            if (willAccept) begin
                accepted++;
                if (accepted < 3) req_addr = addrs[accepted];
                else req_valid = 1'b0;
            end
            if (busy && req_ready) readyBusy++;
            if (resp_valid) begin
                checkOutput($sformatf("held read %0d rdata", seen), resp_rdata, exps[seen]);
                if (seen > 0) checkOutput($sformatf("held read %0d spacing", seen), cyc - lastT, LAT + 2);
                lastT = cyc;
                seen++;
            end
        end
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (resp_valid) extra++;
        end
        checkOutput("held responses", seen, 3);
        checkOutput("held accepts", accepted, 3);
        checkOutput("held ready while busy", readyBusy, 0);
        checkOutput("held extra responses", extra, 0);

        // Reset during BUSY with cnt=1 drops the pending write to block 63.
        req_write = 1'b1;
        req_addr  = 10'h3F0;
        req_wdata = {4{32'hA5A5A5A5}};
        req_wmask = 4'hF;
        req_valid = 1'b1;
        cyc = 0;
        while (!req_ready && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        extra = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (resp_valid) extra++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        modelReset();
        checkOutput("abort state", {req_ready, busy, resp_valid}, 3'b100);
        checkOutput("abort rdata cleared", resp_rdata, 128'h0);
        repeat (8) begin
            @(posedge clk); #1;
            if (resp_valid) extra++;
        end
        checkOutput("abort no response", extra, 0);
        applyStimulus("read 3F0 after abort", 1'b0, 10'h3F0, 128'h0, 4'h0,
                      {32'hFF, 32'hFE, 32'hFD, 32'hFC});

        // Minimum-latency instance: response in the cycle after accept+1.
        req_addr1  = 10'h000;
        req_valid1 = 1'b1;
        cyc = 0;
        while (!req_ready1 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        checkOutput("lat1 after accept", {resp_valid1, busy1}, 2'b01);
        @(posedge clk); #1;
        checkOutput("lat1 resp_valid", resp_valid1, 1'b1);
        checkOutput("lat1 rdata", resp_rdata1, {32'h3, 32'h2, 32'h1, 32'h0});
        @(posedge clk); #1;
        checkOutput("lat1 strobe one cycle", {resp_valid1, req_ready1}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
